// File: rtl/tff_toggle_decoder.sv
// Receive side of the toggle-signalling scheme: synchronises tog_in, turns each level change
// into an event and queues events in a saturating counter behind a valid/ready handshake.
// Optional macro TFF_DEC_STATS_EN adds the 16-bit total_cnt handshake counter output.
module tff_toggle_decoder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tog_in,
    input  logic             evt_ready,
    input  logic             clr_ovf,
    output logic             evt_valid,
    output logic [CNT_W-1:0] pending,
`ifdef TFF_DEC_STATS_EN
    output logic [15:0]      total_cnt,
`endif
    output logic             overflow
);

    localparam logic [0:0] StInit = 1'b0;
    localparam logic [0:0] StRun  = 1'b1;

    // INIT lasts SYNC_STAGES+1 cycles: long enough for tog_last to see the settled level.
    localparam logic [2:0]       InitLast = 3'(SYNC_STAGES);
    localparam logic [CNT_W-1:0] CntMax   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   tog_last_q, tog_last_d;
    logic [0:0]             state_q, state_d;
    logic [2:0]             init_cnt_q, init_cnt_d;
    logic [CNT_W-1:0]       pending_q, pending_d;
    logic                   overflow_q, overflow_d;

    logic tog_s;
    logic evt_det;
    logic hs;
    logic cnt_full;
    logic ovf_set;

    assign tog_s     = sync_q[SYNC_STAGES-1];
    assign evt_det   = (state_q == StRun) & (tog_s ^ tog_last_q);
    assign evt_valid = (pending_q != '0);
    assign hs        = evt_valid & evt_ready;
    assign cnt_full  = (pending_q == CntMax);
    assign pending   = pending_q;
    assign overflow  = overflow_q;

    // Synchroniser, edge history and start-up FSM.
    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], tog_in};
        tog_last_d = tog_s;
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            StInit: begin
                if (init_cnt_q == InitLast) begin
                    state_d = StRun;
                end else begin
                    init_cnt_d = init_cnt_q + 3'd1;
                end
            end
            StRun:   state_d = StRun;
            default: state_d = StInit;
        endcase
    end

    // Pending counter and sticky overflow.
    always_comb begin
        pending_d = pending_q;
        ovf_set   = 1'b0;
        if (evt_det && !hs) begin
            if (cnt_full) begin
                ovf_set = 1'b1;
            end else begin
                pending_d = pending_q + CntOne;
            end
        end else if (hs && !evt_det) begin
            pending_d = pending_q - CntOne;
        end

        // A new drop outranks a clear in the same cycle.
        if (ovf_set) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q     <= '0;
            tog_last_q <= 1'b0;
            state_q    <= StInit;
            init_cnt_q <= 3'd0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            tog_last_q <= tog_last_d;
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef TFF_DEC_STATS_EN
    logic [15:0] total_cnt_q, total_cnt_d;

    assign total_cnt   = total_cnt_q;
    assign total_cnt_d = hs ? total_cnt_q + 16'd1 : total_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            total_cnt_q <= 16'd0;
        end else begin
            total_cnt_q <= total_cnt_d;
        end
    end
`endif

endmodule
